// File: rtl/multiply_stream_if.sv
// -----------------------------------------------------------------------------
// multiply_stream_if
// Bundles the FIFO-facing signals of multiply_stream into one interface.
//
//   x_in_rd_en / y_in_rd_en : pop strobes to the x / y input FIFOs
//   x_in_empty / y_in_empty : empty flags of the x / y input FIFOs
//   x / y                   : head words of the input FIFOs (first-word fall-through)
//   out_wr_en               : push strobe to the output FIFO
//   out_full                : full flag of the output FIFO
//   dout                    : result word, valid while out_wr_en = 1
//   busy                    : at least one pipeline stage holds a valid word
//
// Modports:
//   slave  - the multiply_stream datapath
//   master - the FIFO environment around it
// -----------------------------------------------------------------------------
interface multiply_stream_if #(
  parameter int DATA_SIZE = 32
);
  logic                        x_in_rd_en;
  logic                        y_in_rd_en;
  logic                        x_in_empty;
  logic                        y_in_empty;
  logic signed [DATA_SIZE-1:0] x;
  logic signed [DATA_SIZE-1:0] y;
  logic                        out_wr_en;
  logic                        out_full;
  logic signed [DATA_SIZE-1:0] dout;
  logic                        busy;

  modport slave (
    output x_in_rd_en,
    output y_in_rd_en,
    input  x_in_empty,
    input  y_in_empty,
    input  x,
    input  y,
    output out_wr_en,
    input  out_full,
    output dout,
    output busy
  );

  modport master (
    input  x_in_rd_en,
    input  y_in_rd_en,
    output x_in_empty,
    output y_in_empty,
    output x,
    output y,
    input  out_wr_en,
    output out_full,
    input  dout,
    input  busy
  );
endinterface

// File: rtl/multiply_stream.sv
// -----------------------------------------------------------------------------
// multiply_stream
// Streaming signed fixed-point multiplier between two input FIFOs and one
// output FIFO. Each popped (x, y) pair produces one result:
//   product = x * y                        (signed, 2*DATA_SIZE bits)
//   product += 2^(FRAC_BITS-1)             (only when ROUND = 1)
//   shifted = product >>> FRAC_BITS        (arithmetic shift)
//   result  = low DATA_SIZE bits           (SATURATE = 0, wraps)
//           | clamp to signed range        (SATURATE = 1)
//
// Two registered stages: stage 1 holds the operand pair, stage 2 holds the
// formatted result. Each stage advances when the stage after it can accept,
// giving one result per clock with a 2-cycle pop-to-write latency and at most
// two words in flight under backpressure.
//
// Parameters:
//   DATA_SIZE - operand/result width in bits
//   FRAC_BITS - fractional bits of the fixed-point format (1..DATA_SIZE-1)
//   ROUND     - 0 truncate toward -inf, 1 round half up
//   SATURATE  - 0 wrap, 1 clamp to the signed range
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset, clears all state
//   bus   - FIFO-facing signals (multiply_stream_if.slave)
// -----------------------------------------------------------------------------
module multiply_stream #(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = 10,
  parameter int ROUND     = 0,
  parameter int SATURATE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  multiply_stream_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_SIZE;

  // Adds the rounding bias (if enabled) and drops the fractional bits.
  // The largest product magnitude is 2^(PROD_W-2), so the bias cannot
  // overflow the PROD_W-bit signed container.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] half;
    logic signed [PROD_W-1:0] biased;
    half            = '0;
    half[FRAC_BITS-1] = 1'b1;
    biased          = prod;
    if (ROUND != 0) begin
      biased = prod + half;
    end
    return biased >>> FRAC_BITS;
  endfunction

  // Narrows the shifted value to DATA_SIZE bits, either wrapping or clamping.
  function automatic logic signed [DATA_SIZE-1:0] saturate_fmt(
    input logic signed [PROD_W-1:0] val
  );
    logic signed [PROD_W-1:0] max_v;
    logic signed [PROD_W-1:0] min_v;
    logic signed [DATA_SIZE-1:0] res;
    max_v = {{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    min_v = {{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    res   = val[DATA_SIZE-1:0];
    if (SATURATE != 0) begin
      if (val > max_v) begin
        res = max_v[DATA_SIZE-1:0];
      end else if (val < min_v) begin
        res = min_v[DATA_SIZE-1:0];
      end
    end
    return res;
  endfunction

  // Stage registers and their next-state values
  logic signed [DATA_SIZE-1:0] x_p1_q,   x_p1_d;
  logic signed [DATA_SIZE-1:0] y_p1_q,   y_p1_d;
  logic                        vld_p1_q, vld_p1_d;
  logic signed [DATA_SIZE-1:0] res_p2_q, res_p2_d;
  logic                        vld_p2_q, vld_p2_d;

  logic                        accept1;
  logic                        accept2;
  logic                        pop;
  logic signed [PROD_W-1:0]    prod_p1;
  logic signed [DATA_SIZE-1:0] fmt_p1;

  // Handshake: a stage can take a new word if it is empty or its own word
  // leaves this cycle. Reset gates the pop so no FIFO word is consumed while
  // reset is held.
  always_comb begin
    accept2 = !vld_p2_q || !bus.out_full;
    accept1 = !vld_p1_q || accept2;
    pop     = !reset && !bus.x_in_empty && !bus.y_in_empty && accept1;
  end

  // ---- FIFO heads -> stage 1 ----
  always_comb begin
    x_p1_d   = x_p1_q;
    y_p1_d   = y_p1_q;
    vld_p1_d = vld_p1_q;
    if (accept1) begin
      x_p1_d   = bus.x;
      y_p1_d   = bus.y;
      vld_p1_d = pop;
    end
  end

  // ---- stage 1 -> stage 2 (multiply, round, shift, narrow) ----
  always_comb begin
    prod_p1  = PROD_W'(x_p1_q) * PROD_W'(y_p1_q);
    fmt_p1   = saturate_fmt(round_shift(prod_p1));
    res_p2_d = res_p2_q;
    vld_p2_d = vld_p2_q;
    if (accept2) begin
      res_p2_d = fmt_p1;
      vld_p2_d = vld_p1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_p1_q   <= '0;
      y_p1_q   <= '0;
      vld_p1_q <= 1'b0;
      res_p2_q <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      x_p1_q   <= x_p1_d;
      y_p1_q   <= y_p1_d;
      vld_p1_q <= vld_p1_d;
      res_p2_q <= res_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 2 -> output FIFO ----
  assign bus.x_in_rd_en = pop;
  assign bus.y_in_rd_en = pop;
  assign bus.out_wr_en  = vld_p2_q && !bus.out_full;
  assign bus.dout       = res_p2_q;
  assign bus.busy       = vld_p1_q || vld_p2_q;

endmodule
